apb_uart_master: RTL and testbench
==================================

Name: apb_uart_master

Overview:
- APB initiator that drives register reads and writes into the UART's APB register slave (baud divisor, TX data, RX data, status).
- Accepts one command at a time from a host-side request/response interface and sequences the APB SETUP and ACCESS phases.
- Waits for PREADY, then returns read data or a timeout error.
- Sits between the test/host controller and the UART register block.

Parameters:
- ADDR_WIDTH, 2, width of paddr/cmd_addr (4 registers).
- DATA_WIDTH, 8, width of data buses.
- TIMEOUT_CYCLES, 16, max ACCESS cycles waited for pready; 0 disables timeout.

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- presetn  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  host command request.
- cmd_ready  output  1  master can accept a command this cycle.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_WIDTH  register address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle pulse: transfer complete.
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes and errors).
- rsp_err  output  1  timeout flag, valid with rsp_valid.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB ready.

Behaviour:
- Reset (async assert, sync deassert to pclk):
  - State goes to IDLE.
  - psel, penable, pwrite, rsp_valid and rsp_err are 0.
  - paddr, pwdata and rsp_rdata are 0.
  - Wait counter is 0.
- States and transitions:
  - IDLE: cmd_ready=1 (decoded from state, all other states 0). On cmd_valid at edge N, latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP (cycle N+1): psel=1, penable=0. Unconditionally go to ACCESS.
  - ACCESS (cycle N+2 onward): psel=1, penable=1; counter increments each ACCESS cycle, first ACCESS cycle = 1.
    - pready=1: capture prdata into rsp_rdata if read (0 if write), rsp_err=0, go to RESP.
    - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES: rsp_rdata=0, rsp_err=1, go to RESP.
    - pready=1 on the timeout cycle counts as success.
  - RESP: rsp_valid=1 for exactly this cycle; psel=0, penable=0. Always go to IDLE.
- Outputs: all APB and rsp outputs are registered.
- Latency: with zero wait states, command accepted at edge N gives rsp_valid high during cycle N+3. Each wait state adds one cycle.
- Stability:
  - paddr, pwrite and pwdata are constant from SETUP through the last ACCESS cycle.
  - After completion they retain their last values; psel=0 marks the bus idle.
- Commands:
  - cmd_valid outside IDLE is ignored and not queued.
  - Back-to-back commands: next accept in the IDLE cycle after RESP, so minimum 4 cycles per transfer.
- Responses: no response backpressure; rsp_rdata and rsp_err hold until the next RESP.
- Counter: clears on entry to SETUP; width is clog2(TIMEOUT_CYCLES+1), minimum 1.
- Reset mid-transfer: psel and penable drop immediately, no rsp_valid is issued, and the command is lost.

Test Plan:
- Reset release, cmd_valid=0 -> psel=0, penable=0, cmd_ready=1, rsp_valid never asserted over 20 cycles.
- Write addr=2'b00 data=8'h1B, pready tied 1, accept at N:
  - psel=1 in N+1..N+2, penable=1 only in N+2.
  - paddr=0, pwrite=1, pwdata=8'h1B.
  - rsp_valid pulse in N+3 with rsp_err=0, rsp_rdata=8'h00.
- Read addr=2'b11, pready low for 3 ACCESS cycles then high with prdata=8'hAA -> penable high 4 cycles, paddr stable at 3, rsp_rdata=8'hAA, rsp_err=0.
- pready stuck 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err=1 and rsp_rdata=8'h00; next command is accepted normally.
- cmd_valid held high with two writes (8'h11 to addr 1, 8'h22 to addr 2):
  - cmd_ready low during SETUP/ACCESS/RESP.
  - Second command accepted in the IDLE cycle after the first RESP.
  - Two rsp_valid pulses 4 cycles apart.
- presetn pulsed low during an ACCESS wait state -> psel and penable go 0 asynchronously, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_uart_master_if.sv
// rtl/apb_uart_master_if.sv - host command/response and APB bus bundle for apb_uart_master
interface apb_uart_master_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_uart_master.sv
// rtl/apb_uart_master.sv - single-outstanding APB initiator for the UART register block
module apb_uart_master #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  apb_uart_master_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs are computed for the state being entered so every bus pin comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = CW'(1);
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_uart_master.sv
// tb/tb_apb_uart_master.sv - scoreboard bench for apb_uart_master with a wait-state APB slave model
module tb_apb_uart_master;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 16;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_uart_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_uart_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  typedef struct {
    bit          w;
    logic [1:0]  a;
    logic [7:0]  d;
    logic [7:0]  rd;
    bit          err;
    int          acc;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   rsp_log[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: holds pready low for cur_waits ACCESS cycles, then completes.
  int         cur_waits  = 0;
  logic [7:0] cur_prdata = '0;
  int         acc_n      = 0;
  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      acc_n++;
      bus.pready = (acc_n > cur_waits);
      bus.prdata = (acc_n > cur_waits) ? cur_prdata : 8'($urandom);
    end else begin
      acc_n      = 0;
      bus.pready = 1'b0;
      bus.prdata = 8'($urandom);
    end
  end

  int mon_acc = 0;
  bit mon_in  = 0;
  always @(negedge pclk) begin
    exp_t e;
    if (!presetn) begin
      mon_acc = 0;
      mon_in  = 0;
    end else begin
      if (bus.psel) begin
        if (q.size() == 0) begin
          chk("psel_without_cmd", 1, 0);
        end else begin
          if (!mon_in) begin
            chk("setup_penable", int'(bus.penable), 0);
            mon_in = 1;
          end else begin
            chk("access_penable", int'(bus.penable), 1);
            mon_acc++;
          end
          chk("paddr", int'(bus.paddr), int'(q[0].a));
          chk("pwrite", int'(bus.pwrite), int'(q[0].w));
          chk("pwdata", int'(bus.pwdata), int'(q[0].d));
        end
      end
      if (bus.rsp_valid) begin
        rsp_log.push_back(cyc);
        chk("rsp_psel", int'(bus.psel), 0);
        chk("rsp_penable", int'(bus.penable), 0);
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", int'(bus.rsp_rdata), int'(e.rd));
          chk("rsp_err", int'(bus.rsp_err), int'(e.err));
          chk("access_cycles", mon_acc, e.acc);
          chk("latency", cyc - e.acc_cyc, 1 + e.acc);
        end
        mon_acc = 0;
        mon_in  = 0;
      end
    end
  end

  task automatic issue(input bit w, input logic [1:0] a, input logic [7:0] d,
                       input int waits, input logic [7:0] rd, output int stall);
    exp_t e;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    stall = 0;
    while (!bus.cmd_ready && stall < 200) begin
      @(negedge pclk);
      stall++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    cur_waits  = waits;
    cur_prdata = rd;
    e.w   = w;
    e.a   = a;
    e.d   = d;
    e.err = (waits >= TO);
    e.acc = e.err ? TO : waits + 1;
    e.rd  = (e.err || w) ? 8'h00 : rd;
    @(posedge pclk);
    #1;
    e.acc_cyc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("drain_timeout", int'(q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    int n;
    int n0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_psel", int'(bus.psel), 0);
    chk("rst_penable", int'(bus.penable), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_pwrite", int'(bus.pwrite), 0);
    chk("rst_paddr", int'(bus.paddr), 0);
    chk("rst_pwdata", int'(bus.pwdata), 0);
    chk("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
    chk("rst_rsp_err", int'(bus.rsp_err), 0);
    n = 0;
    repeat (20) begin
      @(negedge pclk);
      if (bus.rsp_valid || bus.psel) n++;
    end
    chk("idle_activity", n, 0);

    issue(1'b1, 2'd0, 8'h1B, 0, 8'h00, st);
    drain();
    issue(1'b0, 2'd3, 8'h00, 3, 8'hAA, st);
    drain();
    issue(1'b0, 2'd1, 8'h00, 1000, 8'h55, st);
    drain();
    issue(1'b1, 2'd2, 8'h5A, 1, 8'h00, st);
    drain();
    issue(1'b0, 2'd2, 8'h00, TO - 1, 8'hC3, st);
    drain();

    issue(1'b1, 2'd1, 8'h11, 0, 8'h00, st);
    issue(1'b1, 2'd2, 8'h22, 0, 8'h00, st);
    chk("b2b_stall", st, 3);
    drain();
    chk("b2b_spacing", rsp_log[rsp_log.size()-1] - rsp_log[rsp_log.size()-2], 4);

    issue(1'b0, 2'd2, 8'h00, 1000, 8'h00, st);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge pclk);
    n0 = rsp_log.size();
    #2;
    presetn = 1'b0;
    #1;
    chk("arst_psel", int'(bus.psel), 0);
    chk("arst_penable", int'(bus.penable), 0);
    q.delete();
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_cmd_ready", int'(bus.cmd_ready), 1);
    repeat (5) @(negedge pclk);
    chk("post_rst_no_rsp", rsp_log.size(), n0);

    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 30)) : int'($urandom_range(0, 4));
      issue(1'($urandom), 2'($urandom), 8'($urandom), w, 8'($urandom), st);
      if ($urandom_range(0, 1) == 1) begin
        bus.cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge pclk);
      end
    end
    drain();
    repeat (3) @(negedge pclk);
    chk("final_queue_empty", int'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
